bus_select_ctrl: RTL and testbench
==================================

BUS_SELECT_CTRL -- requirements
Module: bus_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4, number of chip-select regions (1..8).
REQ-002 SHALL have parameter REGION_BASE, packed NUM_REGIONS x 20 bits, default {0x01C00, 0x0FF00, 0x00000, 0x80000}, with region 0 in the LSBs.
REQ-003 SHALL have parameter REGION_MASK, packed NUM_REGIONS x 20 bits, default {0x0FE00, 0x0FFF0, 0x80000, 0x80000}.
REQ-004 SHALL have parameter REGION_IO, NUM_REGIONS bits, default 4'b1100; a set bit means an I/O region, a clear bit a memory region.
REQ-005 SHALL have parameter REGION_WS, packed NUM_REGIONS x 4 bits, default {3, 2, 0, 1}, giving wait states per region.
REQ-006 SHALL have parameter TIMEOUT, default 64, giving the bus-timeout limit in cycles.
REQ-007 SHALL provide the following ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ALE  in  1  address latch enable.
- IOM  in  1  cycle type: 1 = I/O, 0 = memory.
- RD  in  1  read strobe, active low.
- WR  in  1  write strobe, active low.
- AD  in  8  multiplexed low address byte (sampled only).
- A  in  12  address bits 19:8.
- Address  out  20  latched bus address.
- CS  out  NUM_REGIONS  registered chip selects, active low.
- READY  out  1  wait-state request to the processor (0 = wait).
- BUS_ERR  out  1  one-cycle error pulse.

Function
REQ-008 SHALL implement a state machine with states IDLE, DECODE, WAIT and DONE.
REQ-009 SHALL, in IDLE or DONE, load Address <= {A, AD} and go to DECODE on any edge with ALE=1; ALE SHALL be ignored in DECODE and WAIT.
REQ-010 SHALL define region i as hit when (Address & MASK_i) == (BASE_i & MASK_i) and IOM == REGION_IO[i].
REQ-011 SHALL, when several regions hit, select only the lowest-index region.
REQ-012 SHALL, in DECODE (exactly one cycle), register CS[hit] = 0 with all other CS bits 1, so CS is valid in the cycle after DECODE, and load the wait counter with REGION_WS[hit].
REQ-013 SHALL go from DECODE to WAIT if the loaded wait count is greater than 0, otherwise to DONE.
REQ-014 SHALL decrement the wait counter in WAIT only on cycles where RD=0 or WR=0; the counter SHALL hold while both strobes are high.
REQ-015 SHALL go from WAIT to DONE on the edge where the counter reaches 0.
REQ-016 SHALL drive READY = 0 only in WAIT and READY = 1 in all other states, giving exactly WS low cycles of active strobe.
REQ-017 SHALL, in DONE, hold CS until RD=1 and WR=1, then on the next edge set all CS bits to 1 and go to IDLE (or to DECODE if ALE=1 on that edge).
REQ-018 SHALL, on a miss (no region hit), keep all CS bits at 1, skip WAIT, and go to DONE.
REQ-019 SHALL treat RD=0 and WR=0 together as an active strobe for counting, with no other effect.

Reset
REQ-020 SHALL, with RESET=1 at a rising edge, set Address=0, all CS bits to 1, READY=1, BUS_ERR=0, state to IDLE, and all counters to 0.
REQ-021 SHALL let reset override every other input, including ALE and reset mid-WAIT; READY SHALL be 1 in the cycle after the reset edge.

Configuration
REQ-022 SHALL compile in a bus-timeout monitor when the macro BUS_TIMEOUT_EN is defined.
REQ-023 SHALL, with BUS_TIMEOUT_EN defined, count cycles from DECODE; if the count reaches TIMEOUT before IDLE is re-entered, it SHALL pulse BUS_ERR=1 for one cycle, set all CS bits to 1, hold READY=1, and go to IDLE.
REQ-024 SHALL, with BUS_TIMEOUT_EN defined, also pulse BUS_ERR for one cycle in the cycle after a miss in DECODE.
REQ-025 SHALL, without BUS_TIMEOUT_EN, tie BUS_ERR to 0 and contain no timeout counter, so WAIT and DONE may persist indefinitely.

Verification
REQ-026 Memory read with A=0x800, AD=0x34, IOM=0, RD low SHALL give Address=0x80034, CS=4'b1110, and READY low for exactly 1 strobe cycle.
REQ-027 Memory write to 0x12345 SHALL give CS=4'b1101, keep READY always 1, and raise CS to 4'b1111 one cycle after WR rises.
REQ-028 I/O read of port 0xFF05 SHALL give CS=4'b1011 and READY low for 2 cycles; I/O write to port 0x1C10 SHALL give CS=4'b0111 and READY low for 3 cycles.
REQ-029 I/O access to port 0x0040 (a miss) SHALL keep CS=4'b1111 and READY=1; BUS_ERR SHALL pulse once only when BUS_TIMEOUT_EN is defined.
REQ-030 With BUS_TIMEOUT_EN defined and RD held low for 100 cycles on region 0, BUS_ERR SHALL pulse at cycle 64 after DECODE and CS SHALL return to 4'b1111.
REQ-031 RESET asserted during the second wait state of a region 3 access SHALL give, one edge later, CS=4'b1111, READY=1 and Address=0.

Source files
------------

// File: rtl/bus_select_ctrl.sv
// ----------------------------------------------------------------------------
// bus_select_ctrl
// Chip-select / wait-state controller for a multiplexed 20-bit address bus.
// Latches {A, AD} on ALE, decodes the address against NUM_REGIONS
// base/mask/space windows (lowest index wins), drives one registered
// active-low chip select, and stretches the cycle with READY=0 for the
// region's wait-state count, counting only while a strobe is active.
//
// Ports:
//   CLK      in   1            system clock, rising edge
//   RESET    in   1            synchronous active-high reset
//   ALE      in   1            address latch enable
//   IOM      in   1            cycle type, 1 = I/O, 0 = memory
//   RD       in   1            read strobe, active low
//   WR       in   1            write strobe, active low
//   AD       in   8            multiplexed low address byte
//   A        in   12           address bits 19:8
//   Address  out  20           latched bus address
//   CS       out  NUM_REGIONS  registered chip selects, active low
//   READY    out  1            0 = insert wait state
//   BUS_ERR  out  1            one-cycle error pulse
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : bus-timeout monitor; BUS_ERR pulses on timeout or decode miss.
//   Undefined : BUS_ERR tied to 0, no timeout counter.
// ----------------------------------------------------------------------------
module bus_select_ctrl #(
   parameter int unsigned               NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*20-1:0] REGION_BASE = {20'h01C00, 20'h0FF00, 20'h00000, 20'h80000},
   parameter logic [NUM_REGIONS*20-1:0] REGION_MASK = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
   parameter logic [NUM_REGIONS-1:0]    REGION_IO   = 4'b1100,
   parameter logic [NUM_REGIONS*4-1:0]  REGION_WS   = {4'd3, 4'd2, 4'd0, 4'd1},
   parameter int unsigned               TIMEOUT     = 64
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   ALE,
   input  logic                   IOM,
   input  logic                   RD,
   input  logic                   WR,
   input  logic [7:0]             AD,
   input  logic [11:0]            A,
   output logic [19:0]            Address,
   output logic [NUM_REGIONS-1:0] CS,
   output logic                   READY,
   output logic                   BUS_ERR
);

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned WS_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;

   logic [ADDR_W-1:0]      r_addr;
   logic [ADDR_W-1:0]      w_addr_next;
   logic                   r_iom;
   logic                   w_iom_next;
   logic [NUM_REGIONS-1:0] r_cs;
   logic [NUM_REGIONS-1:0] w_cs_next;
   logic [WS_W-1:0]        r_wait_cnt;
   logic [WS_W-1:0]        w_wait_next;
   logic                   r_ready;
   logic                   w_ready_next;

   logic                   w_hit;
   logic [NUM_REGIONS-1:0] w_hit_sel;
   logic [WS_W-1:0]        w_hit_ws;
   logic                   w_strobe;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TO_W-1:0]        r_to_cnt;
   logic                   r_bus_err;
   logic                   w_bus_err_next;
   logic                   w_timeout;

   // Timeout fires on the edge closing cycle TIMEOUT-1 counted from DECODE.
   assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_W'(TIMEOUT - 1));
`endif

   // Simultaneous RD/WR counts as one active strobe.
   assign w_strobe = ~RD | ~WR;

   // Region decode on the latched address; descending scan so the lowest index wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_sel = '0;
      w_hit_ws  = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (((r_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
              (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) &&
             (r_iom == REGION_IO[i])) begin
            w_hit        = 1'b1;
            w_hit_sel    = '0;
            w_hit_sel[i] = 1'b1;
            w_hit_ws     = REGION_WS[i*WS_W +: WS_W];
         end
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (ALE) w_next_state = S_DECODE;
         end
         S_DECODE: begin
            w_next_state = (w_hit && (w_hit_ws != '0)) ? S_WAIT : S_DONE;
         end
         S_WAIT: begin
            if (w_strobe && (r_wait_cnt == WS_W'(1))) w_next_state = S_DONE;
         end
         S_DONE: begin
            if (ALE)            w_next_state = S_DECODE;
            else if (RD && WR)  w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
`ifdef BUS_TIMEOUT_EN
      if (w_timeout) w_next_state = S_IDLE;
`endif
   end

   // Next values for the registered outputs and datapath.
   always_comb begin
      w_addr_next = r_addr;
      w_iom_next  = r_iom;
      w_cs_next   = r_cs;
      w_wait_next = r_wait_cnt;
`ifdef BUS_TIMEOUT_EN
      w_bus_err_next = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (ALE) begin
               w_addr_next = {A, AD};
               w_iom_next  = IOM;
            end
         end
         S_DECODE: begin
            // w_hit_sel is all zero on a miss, leaving every CS deasserted.
            w_cs_next   = ~w_hit_sel;
            w_wait_next = w_hit ? w_hit_ws : '0;
`ifdef BUS_TIMEOUT_EN
            w_bus_err_next = ~w_hit;
`endif
         end
         S_WAIT: begin
            if (w_strobe) w_wait_next = r_wait_cnt - WS_W'(1);
         end
         S_DONE: begin
            if (ALE) begin
               w_addr_next = {A, AD};
               w_iom_next  = IOM;
               w_cs_next   = '1;
            end else if (RD && WR) begin
               w_cs_next   = '1;
            end
         end
         default: ;
      endcase
`ifdef BUS_TIMEOUT_EN
      if (w_timeout) begin
         w_cs_next      = '1;
         w_wait_next    = '0;
         w_bus_err_next = 1'b1;
      end
`endif
      // READY low exactly while the machine sits in WAIT.
      w_ready_next = (w_next_state != S_WAIT);
   end

   // Datapath and output registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_addr     <= '0;
         r_iom      <= 1'b0;
         r_cs       <= '1;
         r_wait_cnt <= '0;
         r_ready    <= 1'b1;
      end else begin
         r_addr     <= w_addr_next;
         r_iom      <= w_iom_next;
         r_cs       <= w_cs_next;
         r_wait_cnt <= w_wait_next;
         r_ready    <= w_ready_next;
      end
   end

`ifdef BUS_TIMEOUT_EN
   // Cycle counter restarted on every entry to DECODE, cleared in IDLE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_to_cnt  <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_bus_err_next;
         if ((w_next_state == S_DECODE) || (w_next_state == S_IDLE)) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end

   assign BUS_ERR = r_bus_err;
`else
   assign BUS_ERR = 1'b0;
`endif

   assign Address = r_addr;
   assign CS      = r_cs;
   assign READY   = r_ready;

endmodule

// File: tb/tb_bus_select_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bus_select_ctrl
// Scoreboard bench: each bus cycle pushes its expected address, chip select,
// READY-low count and BUS_ERR pulse count; a monitor pops and compares them
// as the DUT responds. Reset behaviour is checked with directed sequences.
// ----------------------------------------------------------------------------
module tb_bus_select_ctrl;

   localparam int unsigned NR = 4;
`ifdef BUS_TIMEOUT_EN
   localparam int ERR_ON = 1;
`else
   localparam int ERR_ON = 0;
`endif

   logic          CLK = 1'b0;
   logic          RESET;
   logic          ALE;
   logic          IOM;
   logic          RD;
   logic          WR;
   logic [7:0]    AD;
   logic [11:0]   A;
   logic [19:0]   Address;
   logic [NR-1:0] CS;
   logic          READY;
   logic          BUS_ERR;

   typedef struct {
      logic [19:0] addr;
      logic [3:0]  cs;
      int          ready_low;
      int          err_cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;

   bus_select_ctrl dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .ALE     (ALE),
      .IOM     (IOM),
      .RD      (RD),
      .WR      (WR),
      .AD      (AD),
      .A       (A),
      .Address (Address),
      .CS      (CS),
      .READY   (READY),
      .BUS_ERR (BUS_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // strb: bit0 = RD active, bit1 = WR active.
   task automatic drive_cycle(input logic iom, input logic [19:0] addr, input logic [1:0] strb,
                              input int dly, input logic [3:0] exp_cs, input int exp_ws,
                              input bit miss);
      exp_t e;
      e.addr      = addr;
      e.cs        = exp_cs;
      e.ready_low = (exp_ws == 0) ? 0 : exp_ws + ((dly > 1) ? dly - 1 : 0);
      e.err_cnt   = miss ? ERR_ON : 0;
      exp_q.push_back(e);
      @(posedge CLK); #1;
      ALE = 1'b1; IOM = iom; A = addr[19:8]; AD = addr[7:0];
      @(posedge CLK); #1;
      ALE = 1'b0; A = 12'($urandom); AD = 8'($urandom);
      repeat (dly) begin @(posedge CLK); #1; end
      RD = ~strb[0]; WR = ~strb[1];
      repeat (exp_ws + 2) begin @(posedge CLK); #1; end
      RD = 1'b1; WR = 1'b1;
      repeat (3) begin @(posedge CLK); #1; end
   endtask

   // Monitor: one scoreboard entry per ALE-started bus cycle.
   initial begin : monitor
      exp_t e;
      int   low;
      int   errs;
      int   n;
      bit   seen;
      forever begin
         @(negedge CLK);
         if (ALE && mon_en) begin
            if (exp_q.size() == 0) begin
               chk_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               e    = exp_q.pop_front();
               low  = 0;
               errs = 0;
               @(negedge CLK);
               chk_eq("addr", Address, e.addr);
               if (!READY)  low++;
               if (BUS_ERR) errs++;
               @(negedge CLK);
               chk_eq("cs", CS, e.cs);
               n    = 0;
               seen = 1'b0;
               while (n < 200) begin
                  if (!READY)  low++;
                  if (BUS_ERR) errs++;
                  if (!RD || !WR) seen = 1'b1;
                  else if (seen)  break;
                  @(negedge CLK);
                  n++;
               end
               chk_eq("window_bound", 32'(n < 200), 32'd1);
               chk_eq("cs_hold", CS, e.cs);
               chk_eq("addr_hold", Address, e.addr);
               @(negedge CLK);
               if (BUS_ERR) errs++;
               chk_eq("cs_release", CS, 32'hF);
               chk_eq("ready_idle", READY, 32'd1);
               chk_eq("ready_low_cnt", low, e.ready_low);
               chk_eq("bus_err_cnt", errs, e.err_cnt);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int first_err;
      int err_pulses;
      RESET = 1'b1; ALE = 1'b1; IOM = 1'b0; RD = 1'b1; WR = 1'b1;
      AD = 8'h34; A = 12'h800;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0; ALE = 1'b0;
      @(negedge CLK);
      chk_eq("rst_addr", Address, 32'h0);
      chk_eq("rst_cs", CS, 32'hF);
      chk_eq("rst_ready", READY, 32'd1);
      chk_eq("rst_bus_err", BUS_ERR, 32'd0);
      mon_en = 1'b1;

      drive_cycle(1'b0, 20'h80034, 2'b01, 0, 4'b1110, 1, 1'b0);
      drive_cycle(1'b0, 20'h12345, 2'b10, 0, 4'b1101, 0, 1'b0);
      drive_cycle(1'b1, 20'h0FF05, 2'b01, 0, 4'b1011, 2, 1'b0);
      drive_cycle(1'b1, 20'h01C10, 2'b10, 0, 4'b0111, 3, 1'b0);
      drive_cycle(1'b1, 20'h00040, 2'b01, 0, 4'b1111, 0, 1'b1);
      drive_cycle(1'b1, 20'h0FF0A, 2'b01, 3, 4'b1011, 2, 1'b0);
      drive_cycle(1'b0, 20'h80000, 2'b01, 0, 4'b1110, 1, 1'b0);
      drive_cycle(1'b0, 20'h7FFFF, 2'b10, 0, 4'b1101, 0, 1'b0);
      drive_cycle(1'b1, 20'h01DFF, 2'b11, 0, 4'b0111, 3, 1'b0);
      drive_cycle(1'b1, 20'h01E00, 2'b10, 0, 4'b1111, 0, 1'b1);
      drive_cycle(1'b1, 20'h0FF10, 2'b01, 0, 4'b1111, 0, 1'b1);
      drive_cycle(1'b0, 20'h01C00, 2'b01, 0, 4'b1101, 0, 1'b0);

      // Reset in the second wait state of a region 3 access, with ALE also high.
      mon_en = 1'b0;
      @(posedge CLK); #1;
      ALE = 1'b1; IOM = 1'b1; A = 12'h01C; AD = 8'h10;
      @(posedge CLK); #1;
      ALE = 1'b0; RD = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk_eq("mid_wait_ready", READY, 32'd0);
      chk_eq("mid_wait_cs", CS, 32'h7);
      RESET = 1'b1; ALE = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0; ALE = 1'b0; RD = 1'b1;
      @(negedge CLK);
      chk_eq("rst_wait_cs", CS, 32'hF);
      chk_eq("rst_wait_ready", READY, 32'd1);
      chk_eq("rst_wait_addr", Address, 32'h0);
      chk_eq("rst_wait_err", BUS_ERR, 32'd0);
      mon_en = 1'b1;
      drive_cycle(1'b1, 20'h0FF00, 2'b01, 0, 4'b1011, 2, 1'b0);

`ifdef BUS_TIMEOUT_EN
      // Region 0 read with RD stuck low for 100 cycles.
      mon_en = 1'b0;
      first_err  = -1;
      err_pulses = 0;
      @(posedge CLK); #1;
      ALE = 1'b1; IOM = 1'b0; A = 12'h800; AD = 8'h00;
      @(posedge CLK); #1;
      ALE = 1'b0; RD = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (BUS_ERR) begin
            err_pulses++;
            if (first_err < 0) first_err = c;
         end
      end
      chk_eq("to_first_cycle", first_err, 64);
      chk_eq("to_pulses", err_pulses, 1);
      chk_eq("to_cs", CS, 32'hF);
      chk_eq("to_ready", READY, 32'd1);
      @(posedge CLK); #1;
      RD = 1'b1;
      mon_en = 1'b1;
`else
      first_err  = 0;
      err_pulses = 0;
`endif

      repeat (5) @(posedge CLK);
      chk_eq("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
